// File: rtl/reg_file_read.sv
// ---------------------------------------------------------------------------
// reg_file_read
//
// Decode/operand-fetch register file for the RV32 pipeline. It takes the
// write-back value, holds the architectural registers (x0 reads as zero), and
// returns two registered source operands. A same-cycle write-back is forwarded
// to the read ports. A per-register pending scoreboard raises a combinational
// stall when a source is still waiting on an in-flight producer.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   wb_en/addr/data     write-back into the array (writes to x0 are dropped)
//   rd_en, rs1/rs2_addr operand read request
//   rs1/rs2_data        registered operands; hold their value when no read fires
//   rd_valid            operands were refreshed by a non-flushed read
//   stall               read-after-write hazard on the current request
//   issue_en, issue_rd  marks issue_rd pending when the instruction leaves decode
//   flush               clears every pending mark
// ---------------------------------------------------------------------------
module reg_file_read #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rd_valid,
    output logic              stall,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              flush
);

    logic [XLEN-1:0]     regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] pend_reg;
    logic [NUM_REGS-1:0] pend_next;
    logic [XLEN-1:0]     rs1_data_reg;
    logic [XLEN-1:0]     rs2_data_reg;
    logic [XLEN-1:0]     rs1_next;
    logic [XLEN-1:0]     rs2_next;
    logic                rd_valid_reg;

    logic wb_write;
    logic haz_rs1;
    logic haz_rs2;
    logic stall_int;
    logic rd_fire;
    logic issue_set;

    assign wb_write = wb_en && (wb_addr != '0);

    // A pending source is released in the very cycle its write-back appears,
    // because the bypass below delivers that value to the read port.
    assign haz_rs1   = pend_reg[rs1_addr] && !(wb_en && (wb_addr == rs1_addr));
    assign haz_rs2   = pend_reg[rs2_addr] && !(wb_en && (wb_addr == rs2_addr));
    assign stall_int = rd_en && (haz_rs1 || haz_rs2);
    assign rd_fire   = rd_en && !stall_int;

    // A stalled decode must not advance, so its issue is ignored.
    assign issue_set = issue_en && !stall_int && !flush && (issue_rd != '0);

    // Per-register pending update. Set is tested before clear so a new
    // producer issued alongside the old producer's write-back stays pending.
    assign pend_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pend
            always_comb begin
                pend_next[gi] = pend_reg[gi];
                if (flush) begin
                    pend_next[gi] = 1'b0;
                end else if (issue_set && (issue_rd == ADDR_W'(gi))) begin
                    pend_next[gi] = 1'b1;
                end else if (wb_en && (wb_addr == ADDR_W'(gi))) begin
                    pend_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Operand select: zero register, then write-through bypass, then array.
    always_comb begin
        rs1_next = regs_reg[rs1_addr];
        rs2_next = regs_reg[rs2_addr];
        if (rs1_addr == '0) begin
            rs1_next = '0;
        end else if (wb_en && (wb_addr == rs1_addr)) begin
            rs1_next = wb_data;
        end
        if (rs2_addr == '0) begin
            rs2_next = '0;
        end else if (wb_en && (wb_addr == rs2_addr)) begin
            rs2_next = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_write) begin
            regs_reg[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg     <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            pend_reg     <= pend_next;
            // Operands are captured even on a flush; only the valid is killed.
            if (rd_fire) begin
                rs1_data_reg <= rs1_next;
                rs2_data_reg <= rs2_next;
            end
            rd_valid_reg <= rd_fire && !flush;
        end
    end

    assign rs1_data = rs1_data_reg;
    assign rs2_data = rs2_data_reg;
    assign rd_valid = rd_valid_reg;
    assign stall    = stall_int;

endmodule

// File: tb/tb_reg_file_read.sv
// ---------------------------------------------------------------------------
// tb_reg_file_read
//
// Directed scenarios followed by randomized traffic. The driver keeps a
// behavioural model (register array plus pending flags) and pushes every
// operand capture into a scoreboard queue; a monitor on the falling clock edge
// pops and compares, and otherwise expects rd_valid low with operands held.
// ---------------------------------------------------------------------------
module tb_reg_file_read;

    logic        clk;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_valid;
    logic        stall;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        flush;

    reg_file_read #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rd_en    (rd_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_valid (rd_valid),
        .stall    (stall),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        logic        valid;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cnt    = 0;
    logic [31:0] m_regs [32];
    logic        m_pend [32];
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input logic w,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (w && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        sb.delete();
    endtask

    // One request cycle: starts and ends 1 time unit after a rising edge.
    task automatic cycle(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iss, input logic [4:0] ird, input logic fl);
        logic  exp_stall;
        exp_t  e;
        rd_en = r; rs1_addr = a1; rs2_addr = a2;
        wb_en = w; wb_addr = wa; wb_data = wd;
        issue_en = iss; issue_rd = ird; flush = fl;
        #1;
        exp_stall = r && ((m_pend[a1] && !(w && wa == a1)) || (m_pend[a2] && !(w && wa == a2)));
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        $display("req cyc=%0d rd=%0b rs1=x%0d rs2=x%0d wb=%0b x%0d=%h iss=%0b x%0d fl=%0b stall=%0b",
                 cnt, r, a1, a2, w, wa, wd, iss, ird, fl, exp_stall);
        if (r && !exp_stall) begin
            e.cyc = cnt; e.valid = !fl;
            e.d1 = mread(a1, w, wa, wd);
            e.d2 = mread(a2, w, wa, wd);
            sb.push_back(e);
        end
        if (w && wa != 0) m_regs[wa] = wd;
        if (fl) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (w) m_pend[wa] = 1'b0;
            if (iss && !exp_stall && ird != 0) m_pend[ird] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            last1 = '0;
            last2 = '0;
        end else if (sb.size() > 0 && sb[0].cyc == cnt - 1) begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, e.valid});
            chk("rs1_data", rs1_data, e.d1);
            chk("rs2_data", rs2_data, e.d2);
            last1 = e.d1;
            last2 = e.d2;
        end else begin
            chk("rd_valid_idle", {31'b0, rd_valid}, 32'h0);
            chk("rs1_hold", rs1_data, last1);
            chk("rs2_hold", rs2_data, last2);
        end
    end

    initial begin
        logic [4:0] a1, a2, wa, ird;
        rst_n = 1'b1;
        {wb_en, rd_en, issue_en, flush} = '0;
        wb_addr = '0; wb_data = '0; rs1_addr = '0; rs2_addr = '0; issue_rd = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_rs1", rs1_data, 32'h0);
        chk("reset_rs2", rs2_data, 32'h0);
        chk("reset_valid", {31'b0, rd_valid}, 32'h0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;

        // Reads after reset and the zero register.
        cycle(1, 0, 5, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Plain write then read.
        cycle(0, 0, 0, 1, 7, 32'h12345678, 0, 0, 0);
        cycle(1, 7, 7, 0, 0, 0, 0, 0, 0);
        // Same-cycle write-through bypass.
        cycle(1, 0, 3, 1, 3, 32'hA5A5A5A5, 0, 0, 0);
        // Hazard on x9, released by its write-back.
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 0);
        repeat (3) cycle(1, 9, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 9, 0, 1, 9, 32'h55, 0, 0, 0);
        cycle(1, 9, 9, 0, 0, 0, 0, 0, 0);
        // Set and clear of x4 in one cycle: set wins.
        cycle(0, 0, 0, 0, 0, 0, 1, 4, 0);
        cycle(0, 0, 0, 1, 4, 32'h1, 1, 4, 0);
        cycle(1, 4, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 4, 0, 1, 4, 32'h2, 0, 0, 0);
        // Flush with x2 and x6 pending; read during flush is not valid.
        cycle(0, 0, 0, 0, 0, 0, 1, 2, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 6, 0);
        cycle(1, 7, 3, 0, 0, 0, 1, 8, 1);
        cycle(1, 2, 6, 0, 0, 0, 0, 0, 0);
        cycle(1, 8, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a read.
        rd_en = 1'b1; rs1_addr = 7; rs2_addr = 3;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rs1", rs1_data, 32'h0);
        chk("midreset_rs2", rs2_data, 32'h0);
        chk("midreset_valid", {31'b0, rd_valid}, 32'h0);
        model_reset();
        rd_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1, 7, 3, 0, 0, 0, 0, 0, 0);

        // Randomized traffic on a narrow address range to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            a1  = 5'($urandom_range(7));
            a2  = 5'($urandom_range(7));
            ird = 5'($urandom_range(7));
            wa  = 5'($urandom_range(7));
            if ($urandom_range(1) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_pend[(int'(wa) + k) % 8]) begin
                        wa = 5'((int'(wa) + k) % 8);
                        break;
                    end
                end
            end
            cycle($urandom_range(9) < 7, a1, a2,
                  $urandom_range(1) == 1, wa, $urandom,
                  $urandom_range(9) < 3, ird, $urandom_range(19) == 0);
        end

        repeat (3) idle();
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
